// File: rtl/common_pkg.sv
// Shared types and constants for the AXI4-Lite command master.
package common_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_RESP = 3'd2,
        RD_REQ  = 3'd3,
        RD_DATA = 3'd4,
        RSP     = 3'd5
    } state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/axi4_lite_master.sv
// Single-outstanding AXI4-Lite master: takes one command, runs the matching
// write (AW+W then B) or read (AR then R) transaction and returns a response.
// All AXI and response outputs come straight from registers.
module axi4_lite_master
    import common_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    // command side
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [31:0]           cmd_wdata,
    input  logic [3:0]            cmd_wstrb,
    // response side
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_write,
    output logic [31:0]           rsp_rdata,
    output logic [1:0]            rsp_resp,
    output logic                  busy,
    // AXI4-Lite master channels
    output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,
    output logic [31:0]           m_axi_wdata,
    output logic [3:0]            m_axi_wstrb,
    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,
    input  logic [1:0]            m_axi_bresp,
    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [31:0]           m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready
);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [3:0]            wstrb_q, wstrb_d;
    logic                  write_q, write_d;
    logic                  awvalid_q, awvalid_d;
    logic                  wvalid_q, wvalid_d;
    logic                  arvalid_q, arvalid_d;
    logic                  aw_done_q, aw_done_d;
    logic                  w_done_q, w_done_d;
    logic                  rsp_write_q, rsp_write_d;
    logic [31:0]           rsp_rdata_q, rsp_rdata_d;
    logic [1:0]            rsp_resp_q, rsp_resp_d;

    logic aw_hs_s;
    logic w_hs_s;

    assign aw_hs_s = awvalid_q & m_axi_awready;
    assign w_hs_s  = wvalid_q & m_axi_wready;

    // Handshake-facing outputs are decoded from the state register or taken
    // from capture registers, so no input reaches an output combinationally.
    assign cmd_ready     = (state_q == IDLE);
    assign busy          = (state_q != IDLE);
    assign rsp_valid     = (state_q == RSP);
    assign m_axi_bready  = (state_q == WR_RESP);
    assign m_axi_rready  = (state_q == RD_DATA);
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_awaddr  = addr_q;
    assign m_axi_araddr  = addr_q;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wstrb   = wstrb_q;
    assign rsp_write     = rsp_write_q;
    assign rsp_rdata     = rsp_rdata_q;
    assign rsp_resp      = rsp_resp_q;

    // Next-state, channel-valid and capture logic for the transaction FSM.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        write_d     = write_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        arvalid_d   = arvalid_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        rsp_write_d = rsp_write_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_resp_d  = rsp_resp_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    // address and strobes pass through untouched, zero strobes included
                    addr_d    = cmd_addr;
                    wdata_d   = cmd_wdata;
                    wstrb_d   = cmd_wstrb;
                    write_d   = cmd_write;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    if (cmd_write) begin
                        state_d   = WR_REQ;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = RD_REQ;
                        arvalid_d = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WR_REQ: begin
                // AW and W complete independently; each valid drops after its own handshake
                if (aw_hs_s) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end else begin
                    awvalid_d = awvalid_q;
                end
                if (w_hs_s) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end else begin
                    wvalid_d = wvalid_q;
                end
                if ((aw_done_q || aw_hs_s) && (w_done_q || w_hs_s)) begin
                    state_d = WR_RESP;
                end else begin
                    state_d = WR_REQ;
                end
            end
            WR_RESP: begin
                if (m_axi_bvalid) begin
                    rsp_write_d = write_q;
                    rsp_rdata_d = 32'h0000_0000;
                    rsp_resp_d  = m_axi_bresp;
                    state_d     = RSP;
                end else begin
                    state_d = WR_RESP;
                end
            end
            RD_REQ: begin
                if (m_axi_arready) begin
                    arvalid_d = 1'b0;
                    state_d   = RD_DATA;
                end else begin
                    state_d = RD_REQ;
                end
            end
            RD_DATA: begin
                if (m_axi_rvalid) begin
                    rsp_write_d = write_q;
                    rsp_rdata_d = m_axi_rdata;
                    rsp_resp_d  = m_axi_rresp;
                    state_d     = RSP;
                end else begin
                    state_d = RD_DATA;
                end
            end
            RSP: begin
                // error responses are reported as-is, never retried
                if (rsp_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = RSP;
                end
            end
            default: begin
                state_d   = IDLE;
                awvalid_d = 1'b0;
                wvalid_d  = 1'b0;
                arvalid_d = 1'b0;
                aw_done_d = 1'b0;
                w_done_d  = 1'b0;
            end
        endcase
    end

    // State and capture registers; reset aborts any transaction at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= {ADDR_WIDTH{1'b0}};
            wdata_q     <= 32'h0000_0000;
            wstrb_q     <= 4'h0;
            write_q     <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= 32'h0000_0000;
            rsp_resp_q  <= 2'b00;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            write_q     <= write_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            arvalid_q   <= arvalid_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            rsp_write_q <= rsp_write_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_resp_q  <= rsp_resp_d;
        end
    end

endmodule
